// File: rtl/iram_axi_arb_if.sv
// ============================================================================
// iram_axi_arb_if : one AXI4-Lite port (aw/w/b/ar/r) with master/slave views
// Rev 1.0
// ============================================================================
`default_nettype none

interface iram_axi_arb_if;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

`default_nettype wire

// File: rtl/iram_axi_arb.sv
// ============================================================================
// iram_axi_arb : round-robin arbiter, two AXI4-Lite masters onto the IRAM port
// Rev 1.0
// ============================================================================
`default_nettype none

module iram_axi_arb (
  input  logic           clk,
  input  logic           rst_n,
  iram_axi_arb_if.slave  m0,
  iram_axi_arb_if.slave  m1,
  iram_axi_arb_if.master s,
  output logic [1:0]     grant_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WADDR = 3'd1,
    WRESP = 3'd2,
    RADDR = 3'd3,
    RDATA = 3'd4
  } state_t;

  state_t r_state, w_state_nxt;
  logic   r_owner, w_owner_nxt;
  logic   r_last_owner, w_last_owner_nxt;
  logic   w_wr_req0, w_wr_req1, w_req0, w_req1, w_pick;

  logic [31:0] w_g_awaddr, w_g_wdata, w_g_araddr;
  logic [2:0]  w_g_awprot, w_g_arprot;
  logic [3:0]  w_g_wstrb;
  logic        w_g_awvalid, w_g_wvalid, w_g_bready, w_g_arvalid, w_g_rready;

  logic        w_gm_awready, w_gm_wready, w_gm_bvalid, w_gm_arready, w_gm_rvalid;
  logic [1:0]  w_gm_bresp, w_gm_rresp;
  logic [31:0] w_gm_rdata;

  assign w_wr_req0 = m0.awvalid & m0.wvalid;
  assign w_wr_req1 = m1.awvalid & m1.wvalid;
  assign w_req0    = w_wr_req0 | m0.arvalid;
  assign w_req1    = w_wr_req1 | m1.arvalid;

  assign w_g_awaddr  = r_owner ? m1.awaddr  : m0.awaddr;
  assign w_g_awprot  = r_owner ? m1.awprot  : m0.awprot;
  assign w_g_awvalid = r_owner ? m1.awvalid : m0.awvalid;
  assign w_g_wdata   = r_owner ? m1.wdata   : m0.wdata;
  assign w_g_wstrb   = r_owner ? m1.wstrb   : m0.wstrb;
  assign w_g_wvalid  = r_owner ? m1.wvalid  : m0.wvalid;
  assign w_g_bready  = r_owner ? m1.bready  : m0.bready;
  assign w_g_araddr  = r_owner ? m1.araddr  : m0.araddr;
  assign w_g_arprot  = r_owner ? m1.arprot  : m0.arprot;
  assign w_g_arvalid = r_owner ? m1.arvalid : m0.arvalid;
  assign w_g_rready  = r_owner ? m1.rready  : m0.rready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_owner <= w_last_owner_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_owner_nxt      = r_owner;
    w_last_owner_nxt = r_last_owner;
    w_pick           = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req0 | w_req1) begin
          // On a tie the master that did not finish last goes first
          w_pick      = (w_req0 & w_req1) ? ~r_last_owner : w_req1;
          w_owner_nxt = w_pick;
          w_state_nxt = (w_pick ? w_wr_req1 : w_wr_req0) ? WADDR : RADDR;
        end
      end
      WADDR: begin
        if (!(w_g_awvalid & w_g_wvalid))
          w_state_nxt = IDLE;
        else if (s.awready & s.wready)
          w_state_nxt = WRESP;
      end
      WRESP: begin
        if (s.bvalid & w_g_bready) begin
          w_state_nxt      = IDLE;
          w_last_owner_nxt = r_owner;
        end
      end
      RADDR: begin
        if (!w_g_arvalid)
          w_state_nxt = IDLE;
        else if (s.arready)
          w_state_nxt = RDATA;
      end
      RDATA: begin
        if (s.rvalid & w_g_rready) begin
          w_state_nxt      = IDLE;
          w_last_owner_nxt = r_owner;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s.awaddr     = 32'd0;
    s.awprot     = 3'd0;
    s.awvalid    = 1'b0;
    s.wdata      = 32'd0;
    s.wstrb      = 4'd0;
    s.wvalid     = 1'b0;
    s.bready     = 1'b0;
    s.araddr     = 32'd0;
    s.arprot     = 3'd0;
    s.arvalid    = 1'b0;
    s.rready     = 1'b0;
    w_gm_awready = 1'b0;
    w_gm_wready  = 1'b0;
    w_gm_bvalid  = 1'b0;
    w_gm_bresp   = 2'd0;
    w_gm_arready = 1'b0;
    w_gm_rvalid  = 1'b0;
    w_gm_rdata   = 32'd0;
    w_gm_rresp   = 2'd0;
    case (r_state)
      WADDR: begin
        s.awaddr     = w_g_awaddr;
        s.awprot     = w_g_awprot;
        s.awvalid    = w_g_awvalid;
        s.wdata      = w_g_wdata;
        s.wstrb      = w_g_wstrb;
        s.wvalid     = w_g_wvalid;
        w_gm_awready = s.awready;
        w_gm_wready  = s.wready;
      end
      WRESP: begin
        s.bready    = w_g_bready;
        w_gm_bvalid = s.bvalid;
        w_gm_bresp  = s.bresp;
      end
      RADDR: begin
        s.araddr     = w_g_araddr;
        s.arprot     = w_g_arprot;
        s.arvalid    = w_g_arvalid;
        w_gm_arready = s.arready;
      end
      RDATA: begin
        s.rready    = w_g_rready;
        w_gm_rvalid = s.rvalid;
        w_gm_rdata  = s.rdata;
        w_gm_rresp  = s.rresp;
      end
      default: ;
    endcase
  end

  // Responses are zero in IDLE, so gating by owner alone silences the loser
  assign m0.awready = w_gm_awready & ~r_owner;
  assign m0.wready  = w_gm_wready  & ~r_owner;
  assign m0.bvalid  = w_gm_bvalid  & ~r_owner;
  assign m0.bresp   = r_owner ? 2'd0 : w_gm_bresp;
  assign m0.arready = w_gm_arready & ~r_owner;
  assign m0.rvalid  = w_gm_rvalid  & ~r_owner;
  assign m0.rdata   = r_owner ? 32'd0 : w_gm_rdata;
  assign m0.rresp   = r_owner ? 2'd0 : w_gm_rresp;

  assign m1.awready = w_gm_awready & r_owner;
  assign m1.wready  = w_gm_wready  & r_owner;
  assign m1.bvalid  = w_gm_bvalid  & r_owner;
  assign m1.bresp   = r_owner ? w_gm_bresp : 2'd0;
  assign m1.arready = w_gm_arready & r_owner;
  assign m1.rvalid  = w_gm_rvalid  & r_owner;
  assign m1.rdata   = r_owner ? w_gm_rdata : 32'd0;
  assign m1.rresp   = r_owner ? w_gm_rresp : 2'd0;

  assign grant_o = (r_state == IDLE) ? 2'b00 : (r_owner ? 2'b10 : 2'b01);

endmodule

`default_nettype wire

// File: tb/tb_iram_axi_arb.sv
// ============================================================================
// tb_iram_axi_arb : scenario bench for iram_axi_arb with an IRAM slave model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_iram_axi_arb;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] grant;

  always #5 clk = ~clk;

  iram_axi_arb_if m0_if ();
  iram_axi_arb_if m1_if ();
  iram_axi_arb_if s_if ();

  iram_axi_arb dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .m0      (m0_if),
    .m1      (m1_if),
    .s       (s_if),
    .grant_o (grant)
  );

  // IRAM slave: always ready, registered responses, SLVERR above 0x100
  logic [31:0] mem [0:15];
  assign s_if.awready = 1'b1;
  assign s_if.wready  = 1'b1;
  assign s_if.arready = 1'b1;

  initial for (int i = 0; i < 16; i++) mem[i] = 32'hA5A5_0000 | i;

  always @(posedge clk)
    if (s_if.awvalid && s_if.wvalid)
      for (int b = 0; b < 4; b++)
        if (s_if.wstrb[b]) mem[s_if.awaddr[5:2]][8*b +: 8] <= s_if.wdata[8*b +: 8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_if.bvalid <= 1'b0;
      s_if.bresp  <= 2'b00;
      s_if.rvalid <= 1'b0;
      s_if.rdata  <= 32'd0;
      s_if.rresp  <= 2'b00;
    end else begin
      if (s_if.bvalid && s_if.bready) s_if.bvalid <= 1'b0;
      if (s_if.awvalid && s_if.wvalid) begin
        s_if.bvalid <= 1'b1;
        s_if.bresp  <= s_if.awaddr[8] ? 2'b10 : 2'b00;
      end
      if (s_if.rvalid && s_if.rready) s_if.rvalid <= 1'b0;
      if (s_if.arvalid) begin
        s_if.rvalid <= 1'b1;
        s_if.rdata  <= mem[s_if.araddr[5:2]];
        s_if.rresp  <= s_if.araddr[8] ? 2'b10 : 2'b00;
      end
    end
  end

  typedef struct {
    int          mi;
    bit          rd;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  exp_t       exp_q[$];
  logic [1:0] grant_log[$];
  int         errors = 0;
  int         checks = 0;

  function automatic logic bv(input int i);  return (i == 0) ? m0_if.bvalid : m1_if.bvalid; endfunction
  function automatic logic br(input int i);  return (i == 0) ? m0_if.bready : m1_if.bready; endfunction
  function automatic logic rv(input int i);  return (i == 0) ? m0_if.rvalid : m1_if.rvalid; endfunction
  function automatic logic rr(input int i);  return (i == 0) ? m0_if.rready : m1_if.rready; endfunction
  function automatic logic [1:0] bresp_of(input int i); return (i == 0) ? m0_if.bresp : m1_if.bresp; endfunction
  function automatic logic [1:0] rresp_of(input int i); return (i == 0) ? m0_if.rresp : m1_if.rresp; endfunction
  function automatic logic [31:0] rdata_of(input int i); return (i == 0) ? m0_if.rdata : m1_if.rdata; endfunction
  function automatic logic outs_active(input int i);
    if (i == 0)
      return m0_if.awready | m0_if.wready | m0_if.bvalid | m0_if.arready | m0_if.rvalid
           | (|m0_if.rdata) | (|m0_if.bresp) | (|m0_if.rresp);
    return m1_if.awready | m1_if.wready | m1_if.bvalid | m1_if.arready | m1_if.rvalid
         | (|m1_if.rdata) | (|m1_if.bresp) | (|m1_if.rresp);
  endfunction

  task automatic clear_all();
    m0_if.awaddr = '0; m0_if.awprot = '0; m0_if.awvalid = 0; m0_if.wdata = '0;
    m0_if.wstrb = '0; m0_if.wvalid = 0; m0_if.bready = 1; m0_if.araddr = '0;
    m0_if.arprot = '0; m0_if.arvalid = 0; m0_if.rready = 1;
    m1_if.awaddr = '0; m1_if.awprot = '0; m1_if.awvalid = 0; m1_if.wdata = '0;
    m1_if.wstrb = '0; m1_if.wvalid = 0; m1_if.bready = 1; m1_if.araddr = '0;
    m1_if.arprot = '0; m1_if.arvalid = 0; m1_if.rready = 1;
  endtask

  task automatic drv_write(input int i, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] st, input logic v);
    if (i == 0) begin
      m0_if.awaddr = a; m0_if.wdata = d; m0_if.wstrb = st; m0_if.awvalid = v; m0_if.wvalid = v;
    end else begin
      m1_if.awaddr = a; m1_if.wdata = d; m1_if.wstrb = st; m1_if.awvalid = v; m1_if.wvalid = v;
    end
  endtask

  task automatic drv_read(input int i, input logic [31:0] a, input logic v);
    if (i == 0) begin m0_if.araddr = a; m0_if.arvalid = v; end
    else begin m1_if.araddr = a; m1_if.arvalid = v; end
  endtask

  task automatic expect_rsp(input int i, input bit rd, input logic [31:0] d, input logic [1:0] r);
    exp_t e;
    e.mi = i; e.rd = rd; e.data = d; e.resp = r;
    exp_q.push_back(e);
  endtask

  // Scoreboard consumer plus per-cycle ownership invariants
  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      checks++;
      if (grant == 2'b11 || (grant != 2'b01 && outs_active(0)) || (grant != 2'b10 && outs_active(1))) begin
        errors++;
        $display("FAIL ownership: grant=%b m0_active=%b m1_active=%b", grant, outs_active(0), outs_active(1));
      end
      checks++;
      if (grant == 2'b00 && (s_if.awvalid | s_if.wvalid | s_if.arvalid | s_if.bready | s_if.rready)) begin
        errors++;
        $display("FAIL idle_slave_quiet: s valids/readies active while grant=00");
      end
      for (int i = 0; i < 2; i++) begin
        if (bv(i) && br(i)) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL bresp_unexpected: m%0d bvalid with nothing pending", i);
          end else begin
            e = exp_q.pop_front();
            if (e.mi != i || e.rd || bresp_of(i) !== e.resp) begin
              errors++;
              $display("FAIL bresp: got m%0d write resp=%b, required m%0d rd=%0d resp=%b",
                       i, bresp_of(i), e.mi, e.rd, e.resp);
            end
          end
        end
        if (rv(i) && rr(i)) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rdata_unexpected: m%0d rvalid with nothing pending", i);
          end else begin
            e = exp_q.pop_front();
            if (e.mi != i || !e.rd || rdata_of(i) !== e.data || rresp_of(i) !== e.resp) begin
              errors++;
              $display("FAIL rdata: got m%0d data=%h resp=%b, required m%0d rd=%0d data=%h resp=%b",
                       i, rdata_of(i), rresp_of(i), e.mi, e.rd, e.data, e.resp);
            end
          end
        end
      end
    end
  endtask

  // Steps cycles, retiring address handshakes, until the scoreboard drains
  task automatic run_drain(input int max_cyc, input int keep0, output bit ok);
    logic [1:0] prev;
    bit hw0, hw1, hr0, hr1;
    int k;
    ok = 0; prev = grant; k = keep0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (prev == 2'b00 && grant != 2'b00) grant_log.push_back(grant);
      prev = grant;
      hw0 = m0_if.awvalid && m0_if.awready && m0_if.wvalid && m0_if.wready;
      hw1 = m1_if.awvalid && m1_if.awready && m1_if.wvalid && m1_if.wready;
      hr0 = m0_if.arvalid && m0_if.arready;
      hr1 = m1_if.arvalid && m1_if.arready;
      @(posedge clk); #1;
      if (hw0) begin m0_if.awvalid = 0; m0_if.wvalid = 0; end
      if (hw1) begin m1_if.awvalid = 0; m1_if.wvalid = 0; end
      if (hr0) begin if (k > 0) k--; else m0_if.arvalid = 0; end
      if (hr1) m1_if.arvalid = 0;
      if (exp_q.size() == 0) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    clear_all();
    drv_read(0, 32'h20, 1);
    drv_write(1, 32'h0, 32'h1, 4'hF, 1);
    repeat (2) @(negedge clk);
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b, want 00", grant); end
    checks++; if (s_if.arvalid !== 1'b0 || s_if.awvalid !== 1'b0) begin
      errors++; $display("FAIL reset_s_valid: arvalid=%b awvalid=%b, want 0", s_if.arvalid, s_if.awvalid); end
    checks++; if (m0_if.arready !== 1'b0 || m1_if.awready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: m0_arready=%b m1_awready=%b, want 0", m0_if.arready, m1_if.awready); end
    clear_all();
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    bit ok;
    drv_read(0, 32'h20, 1);
    drv_read(1, 32'h124, 1);
    expect_rsp(0, 1, 32'hA5A5_0008, 2'b00);
    expect_rsp(1, 1, 32'hA5A5_0009, 2'b10);
    expect_rsp(0, 1, 32'hA5A5_0008, 2'b00);
    grant_log.delete();
    run_drain(60, 1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rr_timeout: %0d responses outstanding, want 0", exp_q.size()); end
    checks++;
    if (grant_log.size() != 3) begin
      errors++; $display("FAIL rr_grants: got %0d grants, want 3", grant_log.size());
    end else if ({grant_log[0], grant_log[1], grant_log[2]} !== 6'b01_10_01) begin
      errors++; $display("FAIL rr_order: got %b %b %b, want 01 10 01", grant_log[0], grant_log[1], grant_log[2]);
    end
    clear_all();
  endtask

  task automatic test_write_read();
    int  hs_c, bv_c;
    bit  ok;
    logic [1:0] g1;
    hs_c = -1; bv_c = -1; g1 = 2'b00;
    @(posedge clk); #1;
    drv_write(0, 32'h10, 32'hDEAD_BEEF, 4'hF, 1);
    expect_rsp(0, 0, 32'h0, 2'b00);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0) begin
        checks++;
        if (grant !== 2'b00 || s_if.awvalid !== 1'b0) begin
          errors++; $display("FAIL wr_registered: cycle0 grant=%b s_awvalid=%b, want 00/0", grant, s_if.awvalid); end
      end
      if (c == 1) begin
        g1 = grant;
        checks++;
        if (s_if.awaddr !== 32'h10 || s_if.wdata !== 32'hDEAD_BEEF || s_if.wstrb !== 4'hF) begin
          errors++; $display("FAIL wr_forward: addr=%h data=%h strb=%h, want 10/deadbeef/f",
                             s_if.awaddr, s_if.wdata, s_if.wstrb); end
      end
      if (m0_if.awready && m0_if.wready && hs_c < 0) hs_c = c;
      if (m0_if.bvalid) begin bv_c = c; break; end
      @(posedge clk); #1;
      if (hs_c == c) drv_write(0, 32'h10, 32'hDEAD_BEEF, 4'hF, 0);
    end
    checks++; if (g1 !== 2'b01) begin errors++; $display("FAIL wr_grant: got %b, want 01", g1); end
    checks++; if (hs_c != 1) begin errors++; $display("FAIL wr_handshake_cycle: got %0d, want 1", hs_c); end
    checks++; if (bv_c != 2) begin errors++; $display("FAIL wr_bvalid_cycle: got %0d, want 2", bv_c); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL wr_idle_after: got %b, want 00", grant); end
    @(posedge clk); #1;
    drv_read(0, 32'h10, 1);
    expect_rsp(0, 1, 32'hDEAD_BEEF, 2'b00);
    run_drain(20, 0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rd_back_timeout: %0d outstanding, want 0", exp_q.size()); end
    clear_all();
  endtask

  task automatic test_write_then_read();
    bit ok;
    @(posedge clk); #1;
    drv_write(1, 32'h04, 32'h1234_5678, 4'b0011, 1);
    drv_read(1, 32'h04, 1);
    expect_rsp(1, 0, 32'h0, 2'b00);
    expect_rsp(1, 1, 32'hA5A5_5678, 2'b00);
    grant_log.delete();
    run_drain(30, 0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wtr_timeout: %0d outstanding, want 0", exp_q.size()); end
    checks++;
    if (grant_log.size() != 2) begin
      errors++; $display("FAIL wtr_grants: got %0d grants, want 2", grant_log.size());
    end else if ({grant_log[0], grant_log[1]} !== 4'b10_10) begin
      errors++; $display("FAIL wtr_owner: got %b %b, want 10 10", grant_log[0], grant_log[1]);
    end
    clear_all();
  endtask

  task automatic test_rready_stall();
    bit seen, ok;
    @(posedge clk); #1;
    m0_if.rready = 0;
    drv_read(0, 32'h10, 1);
    expect_rsp(0, 1, 32'hDEAD_BEEF, 2'b00);
    expect_rsp(1, 1, 32'hA5A5_0009, 2'b10);
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (m0_if.arvalid && m0_if.arready) begin seen = 1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL stall_arready: no m0 arready, want one"); end
    @(posedge clk); #1;
    m0_if.arvalid = 0;
    drv_read(1, 32'h124, 1);
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (m0_if.rvalid) begin seen = 1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL stall_rvalid: no m0 rvalid, want one"); end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      checks++; if (m0_if.rvalid !== 1'b1) begin errors++; $display("FAIL stall_hold: cyc%0d rvalid=%b, want 1", k, m0_if.rvalid); end
      checks++; if (m0_if.rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL stall_data: cyc%0d rdata=%h, want deadbeef", k, m0_if.rdata); end
      checks++; if (grant !== 2'b01) begin errors++; $display("FAIL stall_grant: cyc%0d grant=%b, want 01", k, grant); end
      checks++; if (m1_if.arready !== 1'b0) begin errors++; $display("FAIL stall_m1_wait: cyc%0d m1_arready=%b, want 0", k, m1_if.arready); end
    end
    @(posedge clk); #1;
    m0_if.rready = 1;
    run_drain(30, 0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_timeout: %0d outstanding, want 0", exp_q.size()); end
    clear_all();
  endtask

  task automatic test_aw_only();
    @(posedge clk); #1;
    m1_if.awaddr = 32'h08;
    m1_if.awvalid = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (grant !== 2'b00 || s_if.awvalid !== 1'b0 || m1_if.awready !== 1'b0) begin
        errors++; $display("FAIL aw_only: cyc%0d grant=%b s_awvalid=%b awready=%b, want 00/0/0",
                           k, grant, s_if.awvalid, m1_if.awready); end
    end
    clear_all();
  endtask

  task automatic test_abort();
    bit ok;
    @(posedge clk); #1;
    drv_write(0, 32'h30, 32'hCAFE_0000, 4'hF, 1);
    @(posedge clk); #1;
    drv_write(0, 32'h30, 32'hCAFE_0000, 4'hF, 0);
    @(negedge clk);
    checks++; if (grant !== 2'b01 || s_if.awvalid !== 1'b0) begin
      errors++; $display("FAIL abort_waddr: grant=%b s_awvalid=%b, want 01/0", grant, s_if.awvalid); end
    @(negedge clk);
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL abort_idle: grant=%b, want 00", grant); end
    @(posedge clk); #1;
    drv_read(0, 32'h20, 1);
    drv_read(1, 32'h124, 1);
    expect_rsp(0, 1, 32'hA5A5_0008, 2'b00);
    expect_rsp(1, 1, 32'hA5A5_0009, 2'b10);
    grant_log.delete();
    run_drain(40, 0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL abort_timeout: %0d outstanding, want 0", exp_q.size()); end
    checks++;
    if (grant_log.size() == 0) begin errors++; $display("FAIL abort_last_owner: no grant, want 01 first"); end
    else if (grant_log[0] !== 2'b01) begin errors++; $display("FAIL abort_last_owner: first grant %b, want 01", grant_log[0]); end
    clear_all();
  endtask

  task automatic test_reset_midflight();
    bit seen, ok;
    @(posedge clk); #1;
    m0_if.bready = 0;
    drv_write(0, 32'h38, 32'h0BAD_F00D, 4'hF, 1);
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (m0_if.awready && m0_if.wready) begin seen = 1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL mid_handshake: no write handshake, want one"); end
    @(posedge clk); #1;
    drv_write(0, 32'h38, 32'h0BAD_F00D, 4'hF, 0);
    @(negedge clk);
    checks++; if (m0_if.bvalid !== 1'b1 || grant !== 2'b01) begin
      errors++; $display("FAIL mid_wresp: bvalid=%b grant=%b, want 1/01", m0_if.bvalid, grant); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL mid_async_grant: got %b, want 00", grant); end
    checks++; if (m0_if.bvalid !== 1'b0 || s_if.bready !== 1'b0 || s_if.awvalid !== 1'b0) begin
      errors++; $display("FAIL mid_async_valid: bvalid=%b s_bready=%b s_awvalid=%b, want 0",
                         m0_if.bvalid, s_if.bready, s_if.awvalid); end
    @(negedge clk);
    rst_n = 1'b1;
    m0_if.bready = 1;
    repeat (3) @(posedge clk);
    #1;
    drv_read(0, 32'h10, 1);
    expect_rsp(0, 1, 32'hDEAD_BEEF, 2'b00);
    grant_log.delete();
    run_drain(20, 0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_after_timeout: %0d outstanding, want 0", exp_q.size()); end
    checks++;
    if (grant_log.size() != 1) begin errors++; $display("FAIL mid_after_grant: got %0d grants, want 1", grant_log.size()); end
    else if (grant_log[0] !== 2'b01) begin errors++; $display("FAIL mid_after_grant: got %b, want 01", grant_log[0]); end
    clear_all();
  endtask

  initial begin
    clear_all();
    fork
      monitor_loop();
    join_none
    test_reset();
    test_round_robin();
    test_write_read();
    test_write_then_read();
    test_rready_stall();
    test_aw_only();
    test_abort();
    test_reset_midflight();
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL leftover: %0d responses never arrived, want 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
